// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester handshakes and the FIFO write port that the
// round-robin write arbiter sits between.
// master: the requester/FIFO side that drives valid, data and full.
// slave: the arbiter, which drives ready, the write strobe and status.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
);
  logic [NUM_REQ-1:0]            Req_Valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data;
  logic [NUM_REQ-1:0]            Req_Ready;
  logic                          Wfull;
  logic                          Winc;
  logic [DATA_WIDTH-1:0]         Wdata;
  logic [ID_W-1:0]               Grant_ID;
  logic                          Busy;

  modport master (
    output Req_Valid, Req_Data, Wfull,
    input  Req_Ready, Winc, Wdata, Grant_ID, Busy
  );

  modport slave (
    input  Req_Valid, Req_Data, Wfull,
    output Req_Ready, Winc, Wdata, Grant_ID, Busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
// requesters. A grant lasts for up to BURST_LEN transfers, or until the
// holder drops valid. There is always one IDLE cycle between grants.
// Wfull stalls the holder without giving up the grant.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  fifo_wr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0]      BEAT_LAST = 4'(BURST_LEN - 1);
  localparam logic [ID_W-1:0] LAST_REQ  = ID_W'(NUM_REQ - 1);

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] grant_nxt;
  logic [ID_W-1:0] last_gnt;
  logic [ID_W-1:0] last_nxt;
  logic [3:0]      beat_cnt;
  logic [3:0]      beat_nxt;
  logic [ID_W-1:0] pick;
  logic            pick_found;
  logic            winc;

  // Search for the first valid requester, starting just after the last holder.
  always_comb begin
    int idx;
    idx        = 0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_gnt) + i) % NUM_REQ;
      if (!pick_found && bus.Req_Valid[idx]) begin
        pick       = ID_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // A write happens only when the holder is valid and the FIFO has room.
  // It is also suppressed while reset is asserted, so a burst cut short by
  // reset never writes in the reset cycle.
  assign winc          = (state == GRANT) && bus.Req_Valid[grant_id] && !bus.Wfull && !RST;
  assign bus.Winc      = winc;
  assign bus.Req_Ready = winc ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.Wdata     = bus.Req_Data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign bus.Grant_ID  = grant_id;
  assign bus.Busy      = (state == GRANT);

  // Next-state logic: arbitrate in IDLE, count beats and decide on release in GRANT.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_gnt;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        if (!bus.Req_Valid[grant_id]) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end else if (winc) begin
          if (beat_cnt == BEAT_LAST) begin
            state_nxt = IDLE;
            last_nxt  = grant_id;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 with first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      grant_id <= '0;
      last_gnt <= LAST_REQ;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_gnt <= last_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a table of per-cycle vectors with expected
// outputs, a queue of expected FIFO words, and a randomized tail that
// checks protocol invariants.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int BL = 4;

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       wfull;
    logic       busy;
    logic [1:0] gid;
    logic       winc;
    logic [3:0] ready;
    logic [7:0] wdata;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  int         sent[NR];
  int         errors = 0;
  int         checks = 0;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .ID_W      (IW),
    .BURST_LEN (BL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Free-running write-domain clock.
  always #5 CLK = ~CLK;

  // Safety net in case the design stalls the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_row(input logic rst, input logic [3:0] valid, input logic wfull,
                         input logic busy, input logic [1:0] gid, input logic winc,
                         input logic [7:0] wdata);
    vec_t v;
    v.rst   = rst;
    v.valid = valid;
    v.wfull = wfull;
    v.busy  = busy;
    v.gid   = gid;
    v.winc  = winc;
    v.ready = winc ? (4'b0001 << gid) : 4'b0000;
    v.wdata = wdata;
    vecs.push_back(v);
  endtask

  task automatic add_burst(input logic [3:0] valid, input logic [1:0] gid,
                           input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) add_row(1'b0, valid, 1'b0, 1'b1, gid, 1'b1, first + 8'(i));
  endtask

  // Requester k presents word 0xA0 + 16*k + (words it has already sent).
  task automatic drive(input logic rst, input logic [3:0] valid, input logic wfull);
    @(negedge CLK);
    RST           = rst;
    bus.Req_Valid = valid;
    bus.Wfull     = wfull;
    for (int k = 0; k < NR; k++) bus.Req_Data[k*DW +: DW] = 8'hA0 + 8'(16*k) + 8'(sent[k]);
    #1;
  endtask

  task automatic note_transfers();
    for (int k = 0; k < NR; k++) if (bus.Req_Ready[k] === 1'b1) sent[k]++;
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v.rst, v.valid, v.wfull);
    if (v.winc) sb.push_back(v.wdata);
  endtask

  task automatic check_output(input vec_t v, input int row);
    check($sformatf("row%0d Busy", row), 32'(bus.Busy), 32'(v.busy));
    check($sformatf("row%0d Grant_ID", row), 32'(bus.Grant_ID), 32'(v.gid));
    check($sformatf("row%0d Winc", row), 32'(bus.Winc), 32'(v.winc));
    check($sformatf("row%0d Req_Ready", row), 32'(bus.Req_Ready), 32'(v.ready));
    if (bus.Winc === 1'b1) begin
      if (sb.size() == 0) begin
        check($sformatf("row%0d unexpected write", row), 32'(bus.Wdata), 32'hFFFF_FFFF);
      end else begin
        check($sformatf("row%0d Wdata", row), 32'(bus.Wdata), 32'(sb.pop_front()));
      end
    end
    note_transfers();
  endtask

  initial begin
    logic [3:0] rv;
    logic       rf;
    logic       prev_busy;
    int         burst;
    bit         seen;

    for (int k = 0; k < NR; k++) sent[k] = 0;

    // Reset, then a single requester: 4-word burst, bubble, re-grant for 2 more.
    add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_row(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_burst(4'b0001, 2'd0, 8'hA0, 4);
    add_row(1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_burst(4'b0001, 2'd0, 8'hA4, 2);
    add_row(1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
    add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    // Round robin after a fresh reset: 0,1,2,3,0 with one bubble each.
    add_row(1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_row(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_burst(4'b1111, 2'd0, 8'hA6, 4);
    add_row(1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_burst(4'b1111, 2'd1, 8'hB0, 4);
    add_row(1'b0, 4'b1111, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
    add_burst(4'b1111, 2'd2, 8'hC0, 4);
    add_row(1'b0, 4'b1111, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00);
    add_burst(4'b1111, 2'd3, 8'hD0, 4);
    add_row(1'b0, 4'b1111, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
    add_burst(4'b1111, 2'd0, 8'hAA, 4);
    // Full stall after the 2nd word of requester 2.
    add_row(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_burst(4'b0100, 2'd2, 8'hC4, 2);
    for (int i = 0; i < 3; i++) add_row(1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00);
    add_burst(4'b0100, 2'd2, 8'hC6, 2);
    // Wfull in IDLE does not block arbitration; req 3 then releases unserved.
    add_row(1'b0, 4'b1100, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00);
    add_row(1'b0, 4'b0100, 1'b0, 1'b1, 2'd3, 1'b0, 8'h00);
    add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
    // Early release of requester 1 after two words; it becomes lowest priority.
    add_row(1'b0, 4'b1010, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
    add_burst(4'b1010, 2'd1, 8'hB4, 2);
    add_row(1'b0, 4'b1000, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00);
    add_row(1'b0, 4'b1011, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
    add_row(1'b0, 4'b1011, 1'b0, 1'b1, 2'd3, 1'b1, 8'hD4);
    add_row(1'b0, 4'b0011, 1'b0, 1'b1, 2'd3, 1'b0, 8'h00);
    add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
    // Wrap-around: last holder 3, requests 0 and 2 -> 0 first, then 2.
    add_row(1'b0, 4'b0101, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00);
    add_row(1'b0, 4'b0101, 1'b0, 1'b1, 2'd0, 1'b1, 8'hAE);
    add_row(1'b0, 4'b0100, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
    add_row(1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_row(1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1, 8'hC8);
    add_row(1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 8'h00);
    add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00);
    // Reset during the 3rd beat: no write, priority back to 0, beat count cleared.
    add_row(1'b0, 4'b0010, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00);
    add_burst(4'b0010, 2'd1, 8'hB6, 2);
    add_row(1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00);
    add_row(1'b0, 4'b1010, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
    add_burst(4'b1010, 2'd1, 8'hB8, 4);
    add_row(1'b0, 4'b1000, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00);
    add_row(1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 1'b0, 8'h00);
    add_row(1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0, 8'h00);

    // Two reset cycles before the table starts.
    RST           = 1'b1;
    bus.Req_Valid = '0;
    bus.Wfull     = 1'b0;
    bus.Req_Data  = '0;
    repeat (2) @(posedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i], i);
    end
    check("table scoreboard drained", 32'(sb.size()), 32'd0);

    // Randomized tail: check write gating, one-hot ready, data and burst length.
    prev_busy = 1'b0;
    burst     = 0;
    for (int c = 0; c < 150; c++) begin
      rv = 4'($urandom_range(0, 15));
      rf = ($urandom_range(0, 3) == 0);
      drive(1'b0, rv, rf);
      if (bus.Busy === 1'b1 && prev_busy !== 1'b1) burst = 0;
      check($sformatf("rand%0d no write when full", c), 32'(bus.Winc & bus.Wfull), 32'd0);
      check($sformatf("rand%0d Req_Ready", c), 32'(bus.Req_Ready),
            bus.Winc ? 32'(4'b0001 << bus.Grant_ID) : 32'd0);
      if (bus.Winc === 1'b1) begin
        burst++;
        check($sformatf("rand%0d write needs holder valid", c), 32'(rv[bus.Grant_ID]), 32'd1);
        check($sformatf("rand%0d Wdata", c), 32'(bus.Wdata),
              32'(8'hA0 + 8'(16*int'(bus.Grant_ID)) + 8'(sent[bus.Grant_ID])));
        check($sformatf("rand%0d burst within limit", c), 32'(burst <= BL), 32'd1);
      end
      note_transfers();
      prev_busy = bus.Busy;
    end

    // With room in the FIFO and everyone valid, a write must appear soon.
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      drive(1'b0, 4'b1111, 1'b0);
      if (bus.Winc === 1'b1) seen = 1'b1;
      note_transfers();
    end
    check("write resumes after stall", 32'(seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
